owl_slave: RTL and testbench
============================

OWL_SLAVE -- requirements
Module: owl_slave

Interface
REQ-001 SHALL have parameters, one per line as name, default, meaning:
- START_MIN, 64: minimum low width in clk cycles that counts as a start/resync pulse.
- BIT_TH, 16: low-width threshold between a 0-bit and a 1-bit.
- TIMEOUT, 255: maximum high time in clk cycles inside a frame.
- RD_HOLD, 24: number of cycles the slave holds the line low for a read 0-bit.
REQ-002 SHALL have ports, one per line as name, direction, width, meaning:
- clk, in, 1: single clock; all logic is on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- owl_in, in, 1: raw one-wire line level (asynchronous).
- owl_oe, out, 1: 1 = pull the line low; the pad is open-drain with an external pull-up.
- sfr_addr, out, 7: SFR address of the current access.
- sfr_wdata, out, 8: SFR write data.
- sfr_wr, out, 1: one-cycle write strobe.
- sfr_rd, out, 1: one-cycle read strobe.
- sfr_rdata, in, 8: read data, valid one cycle after sfr_rd.
- busy, out, 1: 1 while not in IDLE.
- frame_err, out, 1: one-cycle pulse on an aborted frame.
REQ-003 SHALL have one clock domain (clk), with the synchronous, active-high reset rst; there is no asynchronous reset path.

Function
REQ-004 SHALL pass owl_in through a 2-flop synchronizer; all timing below is measured on the synchronized level (ls), giving 2 cycles of input latency.
REQ-005 SHALL use an 8-bit low-width counter and an 8-bit high-width counter, both saturating at 255 and cleared on every edge of ls.
REQ-006 SHALL decode each low pulse at the rising edge of ls by its width W:
- W >= START_MIN: start.
- BIT_TH <= W < START_MIN: bit 1.
- W < BIT_TH: bit 0.
REQ-007 SHALL use this frame format, all fields MSB first: start; cmd bit (1 = write, 0 = read); addr[6:0]; then, for a write only, data[7:0].
REQ-008 SHALL implement the states IDLE, RX_HDR, RX_DATA, RD_FETCH, TX_BITS.
REQ-009 IDLE: a start moves to RX_HDR with the bit counter at 0; a data bit received in IDLE is ignored.
REQ-010 RX_HDR: SHALL shift in 8 bits. On the 8th bit, cmd=1 moves to RX_DATA and cmd=0 moves to RD_FETCH; sfr_addr is updated on the 8th bit.
REQ-011 RX_DATA: SHALL shift in 8 bits. On the cycle after the 8th bit's rising edge, SHALL set sfr_wdata, pulse sfr_wr for exactly one cycle, then return to IDLE.
REQ-012 RD_FETCH: SHALL pulse sfr_rd for one cycle, latch sfr_rdata into the shift register on the next cycle, then enter TX_BITS.
REQ-013 TX_BITS: for 8 slots, MSB first, each master-initiated falling edge of ls starts a slot. If the current bit is 0, owl_oe=1 for RD_HOLD cycles; if it is 1, owl_oe stays 0. The bit advances at the end of each slot; after the 8th slot the block returns to IDLE.
REQ-014 SHALL ignore the slave's own drive in TX_BITS: low-width decode is suppressed while owl_oe=1 and for 2 cycles after it (synchronizer delay).
REQ-015 SHALL treat a high time reaching TIMEOUT in any state except IDLE as an abort: pulse frame_err, go to IDLE, clear the bit counter, and set owl_oe=0.
REQ-016 SHALL treat a start received in RX_HDR, RX_DATA or TX_BITS as a resync: pulse frame_err and enter RX_HDR with the bit counter at 0, all in the same cycle.
REQ-017 SHALL never assert sfr_wr for an aborted or resynced frame, and SHALL never assert sfr_wr and sfr_rd in the same cycle.
REQ-018 SHALL hold busy=1 in every state except IDLE.
REQ-019 SHALL allow back-to-back frames: a start may follow the write strobe or the last read slot with no gap beyond normal line timing.

Reset
REQ-020 SHALL, while rst=1, set state=IDLE, and set owl_oe, sfr_wr, sfr_rd, busy and frame_err to 0, sfr_addr to 0x00, sfr_wdata to 0x00, both counters to 0, and the synchronizer flops to 1.
REQ-021 SHALL make rst asserted mid-frame abandon the frame with no strobe and no frame_err, and release owl_oe on the next clk edge.

Verification
REQ-022 Write: start, cmd=1, addr 0x04, data 0x09 -> one sfr_wr pulse with sfr_addr=0x04 and sfr_wdata=0x09; busy falls the next cycle.
REQ-023 Read: start, cmd=0, addr 0x21, sfr_rdata=0xB2, then 8 master slots -> one sfr_rd pulse; the line reads back 1,0,1,1,0,0,1,0.
REQ-024 Pulse widths BIT_TH-1, BIT_TH, START_MIN-1 and START_MIN -> decoded as 0, 1, 1 and start respectively.
REQ-025 Write frame stalled high for TIMEOUT cycles after addr 0x26 -> one frame_err pulse, no sfr_wr, busy=0.
REQ-026 Start after 5 data bits, then a full write of 0x5B to 0x28 -> one frame_err pulse, then exactly one sfr_wr with 0x28/0x5B.
REQ-027 rst=1 during TX_BITS while owl_oe=1 -> owl_oe=0 next cycle, state IDLE, no strobes.

Source files
------------

// File: rtl/owl_slave.sv
// rtl/owl_slave.sv - one-wire SFR slave: pulse-width decoded write/read frames onto a simple SFR bus
// Low pulses are decoded at the rising edge of the synchronized line; reads answer master slots by stretching lows.
module owl_slave #(
  parameter int START_MIN = 64,
  parameter int BIT_TH    = 16,
  parameter int TIMEOUT   = 255,
  parameter int RD_HOLD   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       owl_in,
  output logic       owl_oe,
  output logic [6:0] sfr_addr,
  output logic [7:0] sfr_wdata,
  output logic       sfr_wr,
  output logic       sfr_rd,
  input  logic [7:0] sfr_rdata,
  output logic       busy,
  output logic       frame_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RX_HDR   = 3'd1;
  localparam logic [2:0] S_RX_DATA  = 3'd2;
  localparam logic [2:0] S_RD_FETCH = 3'd3;
  localparam logic [2:0] S_TX_BITS  = 3'd4;

  // Counters hold width-1, so limits are expressed one below the cycle counts.
  localparam logic [7:0] START_LIM = 8'(START_MIN - 1);
  localparam logic [7:0] BIT_LIM   = 8'(BIT_TH - 1);
  localparam logic [7:0] TO_LIM    = 8'(TIMEOUT - 1);
  localparam logic [7:0] HOLD_LIM  = 8'(RD_HOLD - 1);

  logic       sync1_q, sync2_q, ls_prev_q;
  logic [7:0] low_cnt_q, low_cnt_d, high_cnt_q, high_cnt_d;
  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] sup_q, sup_d;
  logic       oe_q, oe_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wr_q, wr_d, rd_q, rd_d, ferr_q, ferr_d;

  logic       ls, rise, fall, suppress, dec_rise, is_start, is_bit, bit_val, timeout, adv;
  logic [7:0] new_shift;

  assign ls        = sync2_q;
  assign rise      = ls & ~ls_prev_q;
  assign fall      = ~ls & ls_prev_q;
  assign suppress  = oe_q | (sup_q != 2'd0);
  assign dec_rise  = rise & ~suppress;
  assign is_start  = dec_rise & (low_cnt_q >= START_LIM);
  assign is_bit    = dec_rise & ~is_start;
  assign bit_val   = (low_cnt_q >= BIT_LIM);
  assign timeout   = (state_q != S_IDLE) & ls & (high_cnt_q >= TO_LIM);
  assign new_shift = {shift_q[6:0], bit_val};

  always_comb begin
    low_cnt_d  = low_cnt_q;
    high_cnt_d = high_cnt_q;
    if (ls != ls_prev_q) begin
      low_cnt_d  = 8'd0;
      high_cnt_d = 8'd0;
    end else if (!ls) begin
      if (low_cnt_q != 8'hFF) low_cnt_d = low_cnt_q + 8'd1;
    end else begin
      if (high_cnt_q != 8'hFF) high_cnt_d = high_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    oe_d      = oe_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    ferr_d    = 1'b0;
    adv       = 1'b0;
    // Release guard spans the synchronizer plus the edge-detect flop.
    sup_d     = (sup_q != 2'd0) ? sup_q - 2'd1 : 2'd0;

    case (state_q)
      S_IDLE: begin
        if (is_start) begin
          state_d   = S_RX_HDR;
          bit_cnt_d = 3'd0;
        end
      end
      S_RX_HDR: begin
        if (is_bit) begin
          shift_d   = new_shift;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d    = new_shift[6:0];
            state_d   = new_shift[7] ? S_RX_DATA : S_RD_FETCH;
            bit_cnt_d = 3'd0;
          end
        end
      end
      S_RX_DATA: begin
        if (wr_q) begin
          state_d = S_IDLE;
        end else if (is_bit) begin
          shift_d   = new_shift;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wdata_d   = new_shift;
            wr_d      = 1'b1;
            bit_cnt_d = 3'd0;
          end
        end
      end
      S_RD_FETCH: begin
        if (bit_cnt_q == 3'd0) begin
          rd_d      = 1'b1;
          bit_cnt_d = 3'd1;
        end else if (bit_cnt_q == 3'd1) begin
          bit_cnt_d = 3'd2;
        end else begin
          shift_d   = sfr_rdata;
          bit_cnt_d = 3'd0;
          state_d   = S_TX_BITS;
        end
      end
      S_TX_BITS: begin
        if (oe_q) begin
          if (hold_q == 8'd0) begin
            oe_d  = 1'b0;
            sup_d = 2'd3;
            adv   = 1'b1;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end else if (fall && !suppress) begin
          if (!shift_q[7]) begin
            oe_d   = 1'b1;
            hold_d = HOLD_LIM;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      shift_d   = {shift_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        state_d   = S_IDLE;
        bit_cnt_d = 3'd0;
      end
    end

    if (is_start && (state_q == S_RX_HDR || state_q == S_RX_DATA || state_q == S_TX_BITS)) begin
      ferr_d    = 1'b1;
      state_d   = S_RX_HDR;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
      wr_d      = 1'b0;
    end

    if (timeout) begin
      ferr_d    = 1'b1;
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
      wr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      ls_prev_q  <= 1'b1;
      low_cnt_q  <= 8'd0;
      high_cnt_q <= 8'd0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      hold_q     <= 8'd0;
      sup_q      <= 2'd0;
      oe_q       <= 1'b0;
      addr_q     <= 7'd0;
      wdata_q    <= 8'd0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= owl_in;
      sync2_q    <= sync1_q;
      ls_prev_q  <= sync2_q;
      low_cnt_q  <= low_cnt_d;
      high_cnt_q <= high_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      sup_q      <= sup_d;
      oe_q       <= oe_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ferr_q     <= ferr_d;
    end
  end

  assign owl_oe    = oe_q;
  assign sfr_addr  = addr_q;
  assign sfr_wdata = wdata_q;
  assign sfr_wr    = wr_q;
  assign sfr_rd    = rd_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_owl_slave.sv
// tb/tb_owl_slave.sv - directed bench for owl_slave with an open-drain line model and SFR read model
module tb_owl_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       master_low = 1'b0;
  logic       owl_in;
  logic       owl_oe;
  logic [6:0] sfr_addr;
  logic [7:0] sfr_wdata;
  logic       sfr_wr, sfr_rd;
  logic [7:0] sfr_rdata = 8'h00;
  logic       busy, frame_err;
  logic [7:0] rd_val = 8'h00;

  int checks = 0;
  int errors = 0;
  int wr_cnt, rd_cnt, fe_cnt, both_cnt;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy_at_wr, busy_after_wr, wr_prev;

  owl_slave dut (
    .clk(clk), .rst(rst), .owl_in(owl_in), .owl_oe(owl_oe),
    .sfr_addr(sfr_addr), .sfr_wdata(sfr_wdata), .sfr_wr(sfr_wr), .sfr_rd(sfr_rd),
    .sfr_rdata(sfr_rdata), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  assign owl_in = (master_low || owl_oe) ? 1'b0 : 1'b1;

  // SFR model: data is only valid the cycle after the read strobe.
  always @(posedge clk) sfr_rdata <= sfr_rd ? rd_val : 8'h00;

  always @(negedge clk) begin
    if (wr_prev) busy_after_wr = busy;
    if (sfr_wr) begin
      wr_cnt++;
      wr_addr = sfr_addr;
      wr_data = sfr_wdata;
      busy_at_wr = busy;
    end
    if (sfr_rd) rd_cnt++;
    if (frame_err) fe_cnt++;
    if (sfr_wr && sfr_rd) both_cnt++;
    wr_prev = sfr_wr;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    wr_cnt = 0; rd_cnt = 0; fe_cnt = 0;
    wr_addr = 7'h00; wr_data = 8'h00;
    busy_at_wr = 1'b0; busy_after_wr = 1'b1;
  endtask

  task automatic pulse(input int w, input int gap);
    master_low = 1'b1;
    cyc(w);
    master_low = 1'b0;
    cyc(gap);
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n, input int w0, input int w1);
    for (int i = 0; i < n; i++) pulse(bits[15-i] ? w1 : w0, 10);
  endtask

  task automatic do_read(input logic [6:0] addr, input logic [7:0] val, output logic [7:0] rb);
    rd_val = val;
    pulse(80, 10);
    send_frame({1'b0, addr, 8'h00}, 8, 6, 30);
    cyc(10);
    for (int i = 0; i < 8; i++) begin
      master_low = 1'b1;
      cyc(4);
      master_low = 1'b0;
      cyc(6);
      rb[7-i] = owl_in;
      cyc(30);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    master_low = 1'b0;
    cyc(3);
    checks++; if (owl_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got %b exp 0", owl_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (sfr_addr !== 7'h00) begin errors++; $display("FAIL rst_addr got %h exp 00", sfr_addr); end
    checks++; if (sfr_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata got %h exp 00", sfr_wdata); end
    checks++; if ({sfr_wr, sfr_rd, frame_err} !== 3'b000) begin errors++; $display("FAIL rst_strobes got %b exp 000", {sfr_wr, sfr_rd, frame_err}); end
    rst = 1'b0;
    cyc(5);
  endtask

  task automatic test_idle_bits();
    clear_mon();
    pulse(63, 10);
    pulse(30, 10);
    pulse(6, 10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL idle_ferr got %0d exp 0", fe_cnt); end
  endtask

  task automatic test_write();
    clear_mon();
    pulse(80, 10);
    send_frame({1'b1, 7'h04, 8'h09}, 16, 6, 30);
    cyc(10);
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL wr_count got %0d exp 1", wr_cnt); end
    checks++; if (wr_addr !== 7'h04) begin errors++; $display("FAIL wr_addr got %h exp 04", wr_addr); end
    checks++; if (wr_data !== 8'h09) begin errors++; $display("FAIL wr_data got %h exp 09", wr_data); end
    checks++; if (busy_at_wr !== 1'b1) begin errors++; $display("FAIL wr_busy_at got %b exp 1", busy_at_wr); end
    checks++; if (busy_after_wr !== 1'b0) begin errors++; $display("FAIL wr_busy_after got %b exp 0", busy_after_wr); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL wr_ferr got %0d exp 0", fe_cnt); end
  endtask

  task automatic test_read();
    logic [7:0] rb;
    clear_mon();
    do_read(7'h21, 8'hB2, rb);
    checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL rd_count got %0d exp 1", rd_cnt); end
    checks++; if (sfr_addr !== 7'h21) begin errors++; $display("FAIL rd_addr got %h exp 21", sfr_addr); end
    checks++; if (rb !== 8'hB2) begin errors++; $display("FAIL rd_line got %h exp b2", rb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_end got %b exp 0", busy); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL rd_no_wr got %0d exp 0", wr_cnt); end
  endtask

  task automatic test_widths();
    clear_mon();
    pulse(64, 10);
    pulse(16, 10);
    send_frame({7'h2A, 8'hC3, 1'b0}, 15, 15, 63);
    cyc(10);
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL width_count got %0d exp 1", wr_cnt); end
    checks++; if (wr_addr !== 7'h2A) begin errors++; $display("FAIL width_addr got %h exp 2a", wr_addr); end
    checks++; if (wr_data !== 8'hC3) begin errors++; $display("FAIL width_data got %h exp c3", wr_data); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL width_ferr got %0d exp 0", fe_cnt); end
  endtask

  task automatic test_timeout();
    clear_mon();
    pulse(80, 10);
    send_frame({1'b1, 7'h26, 8'h00}, 8, 6, 30);
    cyc(300);
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL to_ferr got %0d exp 1", fe_cnt); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL to_no_wr got %0d exp 0", wr_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy got %b exp 0", busy); end
  endtask

  task automatic test_resync();
    clear_mon();
    pulse(80, 10);
    send_frame({1'b1, 7'h11, 8'hFF}, 13, 6, 30);
    pulse(80, 10);
    send_frame({1'b1, 7'h28, 8'h5B}, 16, 6, 30);
    cyc(10);
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL rs_ferr got %0d exp 1", fe_cnt); end
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL rs_count got %0d exp 1", wr_cnt); end
    checks++; if ({wr_addr, wr_data} !== {7'h28, 8'h5B}) begin errors++; $display("FAIL rs_addr_data got %h/%h exp 28/5b", wr_addr, wr_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rb;
    clear_mon();
    pulse(80, 10);
    send_frame({1'b1, 7'h05, 8'hA5}, 16, 6, 30);
    pulse(80, 10);
    send_frame({1'b1, 7'h06, 8'h3C}, 16, 6, 30);
    cyc(10);
    checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", wr_cnt); end
    checks++; if ({wr_addr, wr_data} !== {7'h06, 8'h3C}) begin errors++; $display("FAIL b2b_last got %h/%h exp 06/3c", wr_addr, wr_data); end
    do_read(7'h33, 8'h4D, rb);
    pulse(80, 10);
    send_frame({1'b1, 7'h07, 8'h81}, 16, 6, 30);
    cyc(10);
    checks++; if (rb !== 8'h4D) begin errors++; $display("FAIL b2b_rd_line got %h exp 4d", rb); end
    checks++; if (wr_cnt !== 3) begin errors++; $display("FAIL b2b_after_rd got %0d exp 3", wr_cnt); end
    checks++; if ({wr_addr, wr_data} !== {7'h07, 8'h81}) begin errors++; $display("FAIL b2b_rd_wr got %h/%h exp 07/81", wr_addr, wr_data); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL b2b_ferr got %0d exp 0", fe_cnt); end
  endtask

  task automatic test_rst_tx();
    clear_mon();
    rd_val = 8'hB2;
    pulse(80, 10);
    send_frame({1'b0, 7'h21, 8'h00}, 8, 6, 30);
    cyc(10);
    pulse(4, 36);
    master_low = 1'b1;
    for (int k = 0; k < 20 && owl_oe !== 1'b1; k++) cyc(1);
    checks++; if (owl_oe !== 1'b1) begin errors++; $display("FAIL rt_oe_on got %b exp 1", owl_oe); end
    rst = 1'b1;
    cyc(1);
    checks++; if (owl_oe !== 1'b0) begin errors++; $display("FAIL rt_oe_off got %b exp 0", owl_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rt_busy got %b exp 0", busy); end
    rst = 1'b0;
    master_low = 1'b0;
    cyc(30);
    checks++; if (wr_cnt !== 0 || fe_cnt !== 0) begin errors++; $display("FAIL rt_strobes got wr %0d ferr %0d exp 0 0", wr_cnt, fe_cnt); end
    checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL rt_rd_count got %0d exp 1", rd_cnt); end
  endtask

  initial begin
    both_cnt = 0;
    wr_prev = 1'b0;
    clear_mon();
    test_reset();
    test_idle_bits();
    test_write();
    test_read();
    test_widths();
    test_timeout();
    test_resync();
    test_back_to_back();
    test_rst_tx();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL wr_rd_overlap got %0d exp 0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
